stack_unit_p: RTL and testbench

Parametrised stack unit: a control FSM plus datapath (HD pointer, synchronous-read stack memory) serving one requester through an rdy/ack request interface and an rdy/ack result interface. Successor to the fixed push/pop stack controller. Adds configurable width and depth, overflow/underflow/illegal-op outcome codes, and the TOP, CLEAR, SIZE and MULTIPOP operations. Sits between the processing unit and the stack memory it owns.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_mem.sv | 24 ++
 rtl/stack_unit_p.sv | 176 +++++++++++++++++
 tb/tb_stack_unit_p.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared opcodes, outcome codes and FSM states for the stack unit.
package stack_pkg;

    localparam logic [2:0] OP_PUSH     = 3'd0;
    localparam logic [2:0] OP_POP      = 3'd1;
    localparam logic [2:0] OP_TOP      = 3'd2;
    localparam logic [2:0] OP_CLEAR    = 3'd3;
    localparam logic [2:0] OP_SIZE     = 3'd4;
    localparam logic [2:0] OP_MULTIPOP = 3'd5;

    localparam logic [1:0] ESITO_OK  = 2'd0;
    localparam logic [1:0] ESITO_OVF = 2'd1;
    localparam logic [1:0] ESITO_UNF = 2'd2;
    localparam logic [1:0] ESITO_ILL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/stack_mem.sv
// Single-port stack storage: synchronous write, one-cycle registered read.
module stack_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on we; the read port registers the addressed word every cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_unit_p.sv
// Parametrised stack unit: request/result handshake FSM plus HD pointer datapath.
module stack_unit_p
    import stack_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rdy_in,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic             rdy_out,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       esito,
    input  logic             ack_in,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] HD_FULL = (ADDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   hd_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  din_q;
    logic [WIDTH-1:0]  res_q;
    logic              rd_q;

    logic [ADDR_W:0]   k;
    logic [ADDR_W:0]   hd_m1, hd_mk;
    logic [ADDR_W:0]   hd_n;
    logic [1:0]        esito_n;
    logic [WIDTH-1:0]  res_n;
    logic              rd_n;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;

    assign full  = (hd_q == HD_FULL);
    assign empty = (hd_q == '0);

    assign k     = din_q[ADDR_W:0];
    assign hd_m1 = hd_q - 1'b1;
    assign hd_mk = hd_q - k;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed EXEC->READ->RESP walk, waits only in IDLE and RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rdy_in) state_d = S_EXEC;
            S_EXEC:  state_d = S_READ;
            S_READ:  state_d = S_RESP;
            S_RESP:  if (ack_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Opcode decode and bounds check; memory is driven only while in EXEC.
    always_comb begin
        hd_n     = hd_q;
        esito_n  = ESITO_OK;
        res_n    = '0;
        rd_n     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (op_q)
            OP_PUSH: begin
                if (hd_q == HD_FULL) begin
                    esito_n = ESITO_OVF;
                end else begin
                    mem_we   = 1'b1;
                    mem_addr = hd_q[ADDR_W-1:0];
                    hd_n     = hd_q + 1'b1;
                    res_n    = din_q;
                end
            end
            OP_POP, OP_TOP: begin
                if (hd_q == '0) begin
                    esito_n = ESITO_UNF;
                end else begin
                    mem_addr = hd_m1[ADDR_W-1:0];
                    rd_n     = 1'b1;
                    if (op_q == OP_POP) hd_n = hd_m1;
                end
            end
            OP_CLEAR: begin
                hd_n = '0;
            end
            OP_SIZE: begin
                res_n[ADDR_W:0] = hd_q;
            end
            OP_MULTIPOP: begin
                if (k == '0) begin
                    esito_n = ESITO_ILL;
                end else if (k > hd_q) begin
                    esito_n = ESITO_UNF;
                end else begin
                    mem_addr = hd_mk[ADDR_W-1:0];
                    rd_n     = 1'b1;
                    hd_n     = hd_mk;
                end
            end
            default: begin
                esito_n = ESITO_ILL;
            end
        endcase
        if (state_q != S_EXEC) begin
            mem_we = 1'b0;
        end
    end

    // Datapath registers: latch request, commit EXEC results, present and hold result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hd_q     <= '0;
            op_q     <= '0;
            din_q    <= '0;
            res_q    <= '0;
            rd_q     <= 1'b0;
            ack_out  <= 1'b0;
            rdy_out  <= 1'b0;
            data_out <= '0;
            esito    <= ESITO_OK;
        end else begin
            ack_out <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rdy_in) begin
                        op_q    <= op;
                        din_q   <= data_in;
                        ack_out <= 1'b1;
                    end
                end
                S_EXEC: begin
                    hd_q  <= hd_n;
                    esito <= esito_n;
                    res_q <= res_n;
                    rd_q  <= rd_n;
                end
                S_READ: begin
                    data_out <= rd_q ? mem_rdata : res_q;
                    rdy_out  <= 1'b1;
                end
                S_RESP: begin
                    if (ack_in) rdy_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    stack_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (din_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_stack_unit_p.sv
// Directed bench for stack_unit_p: a 16-deep and a 4-deep instance share stimulus.
module tb_stack_unit_p;
    import stack_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rdy_in;
    logic        ack_in;
    logic [2:0]  op;
    logic [31:0] data_in;

    logic        ack16, rdy16, full16, empty16;
    logic [31:0] dout16;
    logic [1:0]  esito16;
    logic        ack4, rdy4, full4, empty4;
    logic [31:0] dout4;
    logic [1:0]  esito4;

    logic        sel;
    logic        cur_ack, cur_rdy, cur_full, cur_empty;
    logic [31:0] cur_dout;
    logic [1:0]  cur_esito;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign cur_ack   = sel ? ack4   : ack16;
    assign cur_rdy   = sel ? rdy4   : rdy16;
    assign cur_full  = sel ? full4  : full16;
    assign cur_empty = sel ? empty4 : empty16;
    assign cur_dout  = sel ? dout4  : dout16;
    assign cur_esito = sel ? esito4 : esito16;

    stack_unit_p #(.WIDTH(32), .DEPTH(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .rdy_in(rdy_in), .op(op), .data_in(data_in),
        .ack_out(ack16), .rdy_out(rdy16), .data_out(dout16), .esito(esito16),
        .ack_in(ack_in), .full(full16), .empty(empty16)
    );

    stack_unit_p #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .rdy_in(rdy_in), .op(op), .data_in(data_in),
        .ack_out(ack4), .rdy_out(rdy4), .data_out(dout4), .esito(esito4),
        .ack_in(ack_in), .full(full4), .empty(empty4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic [1:0]  exp_esito;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    vec_t vec [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        rdy_in  = 1'b0;
        ack_in  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One full transaction with fixed-latency sampling; returns result and latency flag.
    task automatic do_req(input logic [2:0] o, input logic [31:0] d,
                          output logic [31:0] rd, output logic [1:0] re, output logic lat_ok);
        logic a1, r1, a2, r2, r3, r4;
        @(negedge clock);
        rdy_in  = 1'b1;
        op      = o;
        data_in = d;
        @(posedge clock); #1;
        a1 = cur_ack; r1 = cur_rdy;
        rdy_in = 1'b0;
        @(posedge clock); #1;
        a2 = cur_ack; r2 = cur_rdy;
        @(posedge clock); #1;
        r3 = cur_rdy; rd = cur_dout; re = cur_esito;
        ack_in = 1'b1;
        @(posedge clock); #1;
        r4 = cur_rdy;
        ack_in = 1'b0;
        lat_ok = a1 && !r1 && !a2 && !r2 && r3 && !r4;
    endtask

    task automatic run_chk(input string name, input logic [2:0] o, input logic [31:0] d,
                           input logic [31:0] exp_data, input logic [1:0] exp_esito);
        logic [31:0] rd;
        logic [1:0]  re;
        logic        lat;
        do_req(o, d, rd, re, lat);
        chk({name, "_latency"}, 32'(lat), 32'd1);
        chk({name, "_data"}, rd, exp_data);
        chk({name, "_esito"}, 32'(re), 32'(exp_esito));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic stable, acked, seen;

        reset_n = 1'b0; rdy_in = 1'b0; ack_in = 1'b0; op = '0; data_in = '0; sel = 1'b0;

        vec[0]  = '{OP_PUSH,     32'hA, 32'hA, ESITO_OK,  1'b0, 1'b0};
        vec[1]  = '{OP_PUSH,     32'hB, 32'hB, ESITO_OK,  1'b0, 1'b0};
        vec[2]  = '{OP_PUSH,     32'hC, 32'hC, ESITO_OK,  1'b0, 1'b0};
        vec[3]  = '{OP_SIZE,     32'h0, 32'd3, ESITO_OK,  1'b0, 1'b0};
        vec[4]  = '{OP_POP,      32'h0, 32'hC, ESITO_OK,  1'b0, 1'b0};
        vec[5]  = '{OP_POP,      32'h0, 32'hB, ESITO_OK,  1'b0, 1'b0};
        vec[6]  = '{OP_POP,      32'h0, 32'hA, ESITO_OK,  1'b1, 1'b0};
        vec[7]  = '{OP_POP,      32'h0, 32'h0, ESITO_UNF, 1'b1, 1'b0};
        vec[8]  = '{OP_PUSH,     32'd1, 32'd1, ESITO_OK,  1'b0, 1'b0};
        vec[9]  = '{OP_PUSH,     32'd2, 32'd2, ESITO_OK,  1'b0, 1'b0};
        vec[10] = '{OP_PUSH,     32'd3, 32'd3, ESITO_OK,  1'b0, 1'b0};
        vec[11] = '{OP_PUSH,     32'd4, 32'd4, ESITO_OK,  1'b0, 1'b0};
        vec[12] = '{OP_PUSH,     32'd5, 32'd5, ESITO_OK,  1'b0, 1'b0};
        vec[13] = '{OP_MULTIPOP, 32'd3, 32'd3, ESITO_OK,  1'b0, 1'b0};
        vec[14] = '{OP_SIZE,     32'h0, 32'd2, ESITO_OK,  1'b0, 1'b0};
        vec[15] = '{OP_MULTIPOP, 32'd0, 32'd0, ESITO_ILL, 1'b0, 1'b0};
        vec[16] = '{OP_MULTIPOP, 32'd5, 32'd0, ESITO_UNF, 1'b0, 1'b0};
        vec[17] = '{OP_SIZE,     32'h0, 32'd2, ESITO_OK,  1'b0, 1'b0};
        vec[18] = '{OP_TOP,      32'h0, 32'd2, ESITO_OK,  1'b0, 1'b0};
        vec[19] = '{3'd7,        32'h5, 32'd0, ESITO_ILL, 1'b0, 1'b0};
        vec[20] = '{3'd6,        32'h5, 32'd0, ESITO_ILL, 1'b0, 1'b0};
        vec[21] = '{OP_CLEAR,    32'h0, 32'd0, ESITO_OK,  1'b1, 1'b0};
        vec[22] = '{OP_SIZE,     32'h0, 32'd0, ESITO_OK,  1'b1, 1'b0};
        vec[23] = '{OP_CLEAR,    32'h0, 32'd0, ESITO_OK,  1'b1, 1'b0};

        // Reset state of the 16-deep instance.
        apply_reset();
        #1;
        chk("rst_ack",   32'(cur_ack),   32'd0);
        chk("rst_rdy",   32'(cur_rdy),   32'd0);
        chk("rst_data",  cur_dout,       32'd0);
        chk("rst_esito", 32'(cur_esito), 32'd0);
        chk("rst_empty", 32'(cur_empty), 32'd1);
        chk("rst_full",  32'(cur_full),  32'd0);

        // Table-driven sequence on the 16-deep instance.
        for (int i = 0; i < 24; i++) begin
            run_chk($sformatf("v%0d", i), vec[i].op, vec[i].din, vec[i].exp_data, vec[i].exp_esito);
            chk($sformatf("v%0d_empty", i), 32'(cur_empty), 32'(vec[i].exp_empty));
            chk($sformatf("v%0d_full", i),  32'(cur_full),  32'(vec[i].exp_full));
        end

        // Overflow boundary on the 4-deep instance.
        apply_reset();
        sel = 1'b1;
        run_chk("d4_push1", OP_PUSH, 32'h11, 32'h11, ESITO_OK);
        run_chk("d4_push2", OP_PUSH, 32'h22, 32'h22, ESITO_OK);
        run_chk("d4_push3", OP_PUSH, 32'h33, 32'h33, ESITO_OK);
        chk("d4_not_full", 32'(cur_full), 32'd0);
        run_chk("d4_push4", OP_PUSH, 32'h44, 32'h44, ESITO_OK);
        chk("d4_full", 32'(cur_full), 32'd1);
        run_chk("d4_push5", OP_PUSH, 32'h55, 32'h0, ESITO_OVF);
        chk("d4_full_after_ovf", 32'(cur_full), 32'd1);
        run_chk("d4_size", OP_SIZE, 32'h0, 32'd4, ESITO_OK);
        run_chk("d4_top",  OP_TOP,  32'h0, 32'h44, ESITO_OK);
        sel = 1'b0;

        // Result held across a long ack_in stall; stray rdy_in ignored.
        apply_reset();
        @(negedge clock);
        rdy_in = 1'b1; op = OP_PUSH; data_in = 32'h77;
        @(posedge clock); #1;
        rdy_in = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("hold_rdy_start", 32'(cur_rdy), 32'd1);
        stable = 1'b1;
        acked  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            rdy_in  = (i == 3);
            op      = OP_PUSH;
            data_in = 32'h99;
            @(posedge clock); #1;
            if (!(cur_rdy && cur_dout == 32'h77 && cur_esito == ESITO_OK)) stable = 1'b0;
            if (cur_ack) acked = 1'b1;
        end
        rdy_in = 1'b0;
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_no_ack", 32'(acked),  32'd0);
        @(negedge clock);
        ack_in = 1'b1;
        @(posedge clock); #1;
        ack_in = 1'b0;
        chk("hold_release", 32'(cur_rdy), 32'd0);
        run_chk("hold_size", OP_SIZE, 32'h0, 32'd1, ESITO_OK);

        // Reset asserted while a PUSH is in EXEC.
        @(negedge clock);
        rdy_in = 1'b1; op = OP_PUSH; data_in = 32'h55;
        @(posedge clock); #1;
        rdy_in = 1'b0;
        chk("mid_ack_before", 32'(cur_ack), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_ack",   32'(cur_ack),   32'd0);
        chk("mid_rdy",   32'(cur_rdy),   32'd0);
        chk("mid_data",  cur_dout,       32'd0);
        chk("mid_esito", 32'(cur_esito), 32'd0);
        chk("mid_empty", 32'(cur_empty), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (cur_rdy) seen = 1'b1;
        end
        chk("mid_no_result", 32'(seen), 32'd0);
        run_chk("mid_size", OP_SIZE, 32'h0, 32'd0, ESITO_OK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
